// File: rtl/dsam_stream_arbiter.sv
// dsam_stream_arbiter: round-robin burst arbiter sharing one dsam_encoder between word streams
module dsam_stream_arbiter #(
  parameter int REQUESTERS  = 4,
  parameter int ID_WIDTH    = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int BURST_MAX   = 8,
  parameter int ENC_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [REQUESTERS-1:0]            req_valid,
  input  logic [REQUESTERS-1:0]            req_last,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] req_data,
  output logic [REQUESTERS-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]            enc_in,
  input  logic [DATA_WIDTH-1:0]            enc_out,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic [ID_WIDTH-1:0]              out_id,
  output logic                             busy
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam int CW = $clog2(BURST_MAX + 1);
  logic [0:0] state;
  logic [ID_WIDTH-1:0] rr_ptr, owner, pick, next_ptr;
  logic [CW-1:0] count;
  logic [ENC_LATENCY-1:0] v_pipe;
  logic [ID_WIDTH-1:0] id_pipe [ENC_LATENCY];
  logic xfer, rel;
  int idx;
  always_comb begin
    pick = rr_ptr;
    idx = 0;
    // scan downward so the requester nearest rr_ptr is the last one written
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % REQUESTERS;
      if (req_valid[idx]) pick = ID_WIDTH'(idx);
    end
  end
  assign busy      = (state == GRANT);
  assign req_ready = busy ? (REQUESTERS'(1) << owner) : '0;
  assign xfer      = busy && req_valid[owner];
  assign rel       = busy && (!req_valid[owner] || req_last[owner] || count == CW'(BURST_MAX - 1));
  assign next_ptr  = (owner == ID_WIDTH'(REQUESTERS - 1)) ? '0 : owner + 1'b1;
  assign out_data  = enc_out;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      count  <= '0;
      enc_in <= '0;
    end else if (!busy) begin
      if (|req_valid) begin
        owner <= pick;
        count <= '0;
        state <= GRANT;
      end
    end else begin
      if (xfer) begin
        enc_in <= req_data[owner*DATA_WIDTH +: DATA_WIDTH];
        count  <= count + 1'b1;
      end
      if (rel) begin
        state  <= IDLE;
        rr_ptr <= next_ptr;
      end
    end
  end
  // the extra output register covers the encoder's own input register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_pipe    <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      for (int i = 0; i < ENC_LATENCY; i++) id_pipe[i] <= '0;
    end else begin
      v_pipe[0]  <= xfer;
      id_pipe[0] <= owner;
      for (int i = 1; i < ENC_LATENCY; i++) begin
        v_pipe[i]  <= v_pipe[i-1];
        id_pipe[i] <= id_pipe[i-1];
      end
      out_valid <= v_pipe[ENC_LATENCY-1];
      if (v_pipe[ENC_LATENCY-1]) out_id <= id_pipe[ENC_LATENCY-1];
    end
  end
endmodule

// File: doc/dsam_stream_arbiter.md
Name: dsam_stream_arbiter

Overview:
- Shares one dsam_encoder instance between REQUESTERS independent word streams using round-robin burst arbitration.
- Accepts words over per-requester valid/ready handshakes and drives the encoder input bus.
- Re-aligns the encoder output with a valid flag and the source requester ID, compensating for encoder latency.
- Sits directly in front of dsam_encoder; the encoder itself has no handshake, so this block owns all sequencing.

Parameters:
REQUESTERS, 4, number of requesting streams
ID_WIDTH, 2, width of requester ID; must satisfy 2^ID_WIDTH >= REQUESTERS
DATA_WIDTH, 16, word width; must match encoder DATA_WIDTH
BURST_MAX, 8, maximum words per grant before forced rotation (>=1)
ENC_LATENCY, 1, clock cycles from enc_in change to matching enc_out

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  REQUESTERS  per-requester word valid
req_last  in  REQUESTERS  per-requester end-of-burst marker, qualified by valid
req_data  in  REQUESTERS*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  REQUESTERS  per-requester accept; at most one bit high
enc_in  out  DATA_WIDTH  registered word to encoder input
enc_out  in  DATA_WIDTH  encoder output
out_data  out  DATA_WIDTH  combinational passthrough of enc_out
out_valid  out  1  out_data is an encoded accepted word
out_id  out  ID_WIDTH  requester ID of the word on out_data
busy  out  1  high in GRANT state

Behaviour:
- Reset values (async assert):
  - state IDLE, rr_ptr 0, owner 0, burst count 0.
  - enc_in 0, req_ready all 0, out_valid 0, out_id 0, busy 0.
  - Valid/ID delay pipeline cleared.
- IDLE state:
  - req_ready all 0.
  - If any req_valid is high, grant the first requester searching from rr_ptr upward, wrapping modulo REQUESTERS.
  - On grant: owner <= that index, count <= 0, state <= GRANT.
  - Otherwise stay in IDLE.
- GRANT state:
  - busy = 1.
  - req_ready[owner] = 1 (combinational from state/owner); all other bits are 0.
- Transfer:
  - Occurs when req_valid[owner] && req_ready[owner].
  - On the transfer edge: enc_in <= req_data[owner], count <= count+1.
  - Push valid=1 and id=owner into the delay pipeline.
- Release (return to IDLE, rr_ptr <= (owner+1) mod REQUESTERS) on any of the following; if several coincide, a single release occurs:
  - a transfer with req_last[owner]=1;
  - a transfer with count == BURST_MAX-1;
  - a cycle in GRANT with req_valid[owner]=0. The bubble counts as a drop; the requester must re-arbitrate.
- There is exactly one IDLE cycle between consecutive grants; back-to-back grants without it are not permitted.
- Non-transfer cycles:
  - enc_in holds its previous value, so the encoder sees a repeated word.
  - Push valid=0 into the pipeline; out_id holds its last value.
- Output alignment:
  - out_valid/out_id equal the pipeline entry pushed ENC_LATENCY cycles after the transfer edge.
  - With ENC_LATENCY=1, out_valid rises on the edge following the transfer edge, matching enc_out of that word.
  - The pipeline is ENC_LATENCY deep shift registers.
- Fairness: a requester whose req_valid stays high is granted within REQUESTERS grants.
- req_last on a non-owner, or while not ready, is ignored.
- Reset mid-burst: immediate abort, all state to reset values; in-flight pipeline entries are discarded (out_valid 0).
- REQUESTERS not a power of two: rr_ptr and owner wrap at REQUESTERS-1 → 0.

Test Plan:
- Single requester 0 sends 3 words 0x6396, 0x65B2, 0xC221, last on the third:
  - req_ready[0] high 3 cycles;
  - enc_in follows the words;
  - out_valid high for 3 cycles, one cycle later, out_id=0;
  - then one IDLE cycle with busy=0.
- All 4 requesters valid continuously with bursts of 2 words:
  - grant order is 0,1,2,3,0;
  - one idle cycle between grants;
  - out_id sequence is 0,0,1,1,2,2,3,3.
- Requester 2 streams 12 words with no last, BURST_MAX=8:
  - release after 8 transfers;
  - requester 2 regranted after the idle cycle when it is the only one valid;
  - remaining 4 words delivered.
- Requester 1 drops req_valid after 1 word mid-grant while requester 3 is waiting:
  - release next cycle;
  - requester 3 granted after the IDLE cycle;
  - rr_ptr=2.
- Reset asserted mid-burst of requester 0 (after 2 of 5 words):
  - req_ready 0, out_valid 0, enc_in 0 immediately;
  - after deassert, requester 0 is granted first, from rr_ptr=0.
- No requests for 10 cycles:
  - enc_in stays at the last word;
  - out_valid stays 0;
  - busy stays 0.
